// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Optional loss-of-lock counters are built when PLL_SUPERVISOR_LOL_COUNTER_EN is defined.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    DEBOUNCE  = 3'd2,
    LOCKED    = 3'd3,
    FAULT     = 3'd4
  } pll_chan_state_t;

  localparam int unsigned LOL_COUNT_WIDTH = 8;

endpackage

// File: rtl/pll_lock_channel.sv
// One supervised PLL: lock synchroniser, reset/retry FSM and debounce.
// Macro PLL_SUPERVISOR_LOL_COUNTER_EN adds a saturating loss-of-lock counter.
module pll_lock_channel
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned RESET_HOLD      = 16,
  parameter int unsigned LOCK_TIMEOUT    = 125000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lock_async,
  input  logic                       clear_fault,
  output logic                       pll_reset,
  output logic                       fault,
  output logic                       locked,
  output logic [LOL_COUNT_WIDTH-1:0] lol_count
);

  localparam int unsigned HOLD_W  = $clog2(RESET_HOLD + 1);
  localparam int unsigned TMR_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  pll_chan_state_t     state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                lock_meta_q, lock_s_q;
  logic                pll_reset_q, pll_reset_d;
  logic                fault_q, fault_d;
  logic                locked_q, locked_d;

  // Two-flop synchroniser for the asynchronous LOCKED pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock_async;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_PLL;
      hold_q      <= '0;
      timer_q     <= '0;
      deb_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      fault_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      timer_q     <= timer_d;
      deb_q       <= deb_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      fault_q     <= fault_d;
      locked_q    <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    deb_d   = deb_q;
    retry_d = retry_q;
    unique case (state_q)
      RESET_PLL: begin
        if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = DEBOUNCE;
          deb_d   = '0;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + RETRY_W'(1);
          if (retry_d < RETRY_W'(MAX_RETRIES)) begin
            state_d = RESET_PLL;
            hold_d  = '0;
          end else begin
            state_d = FAULT;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // A dropout always wins, even on the final debounce cycle
      DEBOUNCE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d = LOCKED;
          retry_d = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      LOCKED: begin
        if (!lock_s_q) begin
          state_d = RESET_PLL;
          hold_d  = '0;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d = RESET_PLL;
          hold_d  = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        hold_d  = '0;
      end
    endcase
    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAULT);
    fault_d     = (state_d == FAULT);
    locked_d    = (state_d == LOCKED);
  end

  assign pll_reset = pll_reset_q;
  assign fault     = fault_q;
  assign locked    = locked_q;

`ifdef PLL_SUPERVISOR_LOL_COUNTER_EN
  logic [LOL_COUNT_WIDTH-1:0] lol_q, lol_d;

  always_comb begin
    lol_d = lol_q;
    if ((state_q == LOCKED) && !lock_s_q && (lol_q != '1)) begin
      lol_d = lol_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lol_q <= '0;
    end else begin
      lol_q <= lol_d;
    end
  end

  assign lol_count = lol_q;
`else
  assign lol_count = '0;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// N-channel PLL lock supervisor with ordered, staggered domain reset release.
// Optional per-channel loss-of-lock counters via PLL_SUPERVISOR_LOL_COUNTER_EN.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned NUM_PLLS        = 2,
  parameter int unsigned RESET_HOLD      = 16,
  parameter int unsigned LOCK_TIMEOUT    = 125000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned STAGGER         = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PLLS-1:0]                 pll_lock_async,
  input  logic [NUM_PLLS-1:0]                 clear_fault,
  output logic [NUM_PLLS-1:0]                 pll_reset,
  output logic [NUM_PLLS-1:0]                 domain_rst,
  output logic [NUM_PLLS-1:0]                 fault,
  output logic                                all_ready,
  output logic [LOL_COUNT_WIDTH*NUM_PLLS-1:0] lol_count
);

  localparam int unsigned STG_W = $clog2(STAGGER + 1);

  logic [NUM_PLLS-1:0]            ch_locked;
  logic [NUM_PLLS-1:0]            rel_q, rel_d;
  logic [NUM_PLLS-1:0][STG_W-1:0] stg_q, stg_d;
  logic                           all_ready_q, all_ready_d;
  logic                           chain_ok;
  logic                           prev_rel;
  logic                           cond;

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
    pll_lock_channel #(
      .RESET_HOLD      (RESET_HOLD),
      .LOCK_TIMEOUT    (LOCK_TIMEOUT),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .MAX_RETRIES     (MAX_RETRIES)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .lock_async  (pll_lock_async[i]),
      .clear_fault (clear_fault[i]),
      .pll_reset   (pll_reset[i]),
      .fault       (fault[i]),
      .locked      (ch_locked[i]),
      .lol_count   (lol_count[LOL_COUNT_WIDTH*i +: LOL_COUNT_WIDTH])
    );
  end

  // chain_ok drops for every domain at or above a channel that is not locked,
  // so a lock loss on channel k pulls domains k..N-1 back into reset together.
  always_comb begin
    rel_d    = '0;
    stg_d    = stg_q;
    chain_ok = 1'b1;
    prev_rel = 1'b1;
    cond     = 1'b0;
    for (int unsigned i = 0; i < NUM_PLLS; i++) begin
      chain_ok = chain_ok & ch_locked[i];
      cond     = chain_ok & prev_rel;
      if (!cond) begin
        stg_d[i] = '0;
        rel_d[i] = 1'b0;
      end else if (rel_q[i]) begin
        rel_d[i] = 1'b1;
      end else if (stg_q[i] == STG_W'(STAGGER - 1)) begin
        rel_d[i] = 1'b1;
      end else begin
        stg_d[i] = stg_q[i] + 1'b1;
      end
      prev_rel = rel_q[i];
    end
    all_ready_d = &rel_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rel_q       <= '0;
      stg_q       <= '0;
      all_ready_q <= 1'b0;
    end else begin
      rel_q       <= rel_d;
      stg_q       <= stg_d;
      all_ready_q <= all_ready_d;
    end
  end

  assign domain_rst = ~rel_q;
  assign all_ready  = all_ready_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor against a cycle-level behavioural model.
module tb_pll_lock_supervisor;

  localparam int N    = 2;
  localparam int HOLD = 2;
  localparam int TMO  = 20;
  localparam int DEB  = 4;
  localparam int MAXR = 2;
  localparam int STG  = 3;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_DEB  = 2;
  localparam int P_LOCK = 3;
  localparam int P_FLT  = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   lock_in;
  logic [N-1:0]   clr;
  logic [N-1:0]   pll_reset;
  logic [N-1:0]   domain_rst;
  logic [N-1:0]   fault;
  logic           all_ready;
  logic [8*N-1:0] lol_count;

  int n_tests;
  int n_fail;

  // Model state: phase, cycles spent in phase, failed tries, lock-loss events
  int ph[N];
  int since[N];
  int tries[N];
  int lol[N];
  int run[N];
  bit rel[N];
  bit s1[N];
  bit s2[N];

  pll_lock_supervisor #(
    .NUM_PLLS        (N),
    .RESET_HOLD      (HOLD),
    .LOCK_TIMEOUT    (TMO),
    .DEBOUNCE_CYCLES (DEB),
    .MAX_RETRIES     (MAXR),
    .STAGGER         (STG)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_lock_async (lock_in),
    .clear_fault    (clr),
    .pll_reset      (pll_reset),
    .domain_rst     (domain_rst),
    .fault          (fault),
    .all_ready      (all_ready),
    .lol_count      (lol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = P_RST; since[i] = 0; tries[i] = 0; lol[i] = 0;
      run[i] = 0; rel[i] = 0; s1[i] = 0; s2[i] = 0;
    end
  endtask

  task automatic enter(input int i, input int p);
    ph[i]    = p;
    since[i] = 0;
  endtask

  task automatic model_edge();
    bit ok, prev, old, ls, c;
    if (reset) begin
      model_reset();
      return;
    end
    // Release chain, judged on the phases held before this edge
    ok = 1; prev = 1;
    for (int i = 0; i < N; i++) begin
      ok = ok && (ph[i] == P_LOCK);
      c  = ok && prev;
      run[i] = c ? run[i] + 1 : 0;
      old    = rel[i];
      rel[i] = c && (run[i] >= STG);
      prev   = old;
    end
    for (int i = 0; i < N; i++) begin
      ls = s2[i]; s2[i] = s1[i]; s1[i] = lock_in[i];
      since[i]++;
      case (ph[i])
        P_RST:  if (since[i] >= HOLD) enter(i, P_WAIT);
        P_WAIT: begin
          if (ls) enter(i, P_DEB);
          else if (since[i] >= TMO) begin
            tries[i]++;
            enter(i, (tries[i] < MAXR) ? P_RST : P_FLT);
          end
        end
        P_DEB: begin
          if (!ls) enter(i, P_WAIT);
          else if (since[i] >= DEB) begin
            tries[i] = 0;
            enter(i, P_LOCK);
          end
        end
        P_LOCK: begin
          if (!ls) begin
            if (lol[i] < 255) lol[i]++;
            enter(i, P_RST);
          end
        end
        default: begin
          if (clr[i]) begin
            tries[i] = 0;
            enter(i, P_RST);
          end
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]   e_pr, e_dr, e_f;
    logic           e_ar;
    logic [8*N-1:0] e_lol;
    e_ar = 1'b1;
    e_lol = '0;
    for (int i = 0; i < N; i++) begin
      e_pr[i] = (ph[i] == P_RST) || (ph[i] == P_FLT);
      e_f[i]  = (ph[i] == P_FLT);
      e_dr[i] = !rel[i];
      e_ar    = e_ar & rel[i];
`ifdef PLL_SUPERVISOR_LOL_COUNTER_EN
      e_lol[8*i +: 8] = 8'(lol[i]);
`endif
    end
    check_eq("pll_reset",  32'(pll_reset),  32'(e_pr));
    check_eq("domain_rst", 32'(domain_rst), 32'(e_dr));
    check_eq("fault",      32'(fault),      32'(e_f));
    check_eq("all_ready",  32'(all_ready),  32'(e_ar));
    check_eq("lol_count",  32'(lol_count),  32'(e_lol));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clr   = '0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    lock_in = '0;
    clr     = '0;
    model_reset();
    step(2);
    check_eq("reset_domain_rst", 32'(domain_rst), 32'h3);
    check_eq("reset_pll_reset",  32'(pll_reset),  32'h3);
    check_eq("reset_all_ready",  32'(all_ready),  32'h0);
    reset = 1'b0;

    // Clean bring-up, locks high from cycle 10
    for (int c = 0; c < 45; c++) begin
      if (c == 10) lock_in = 2'b11;
      step(1);
      if (c == 2) check_eq("bringup_pll_reset_low", 32'(pll_reset), 32'h0);
    end
    check_eq("bringup_all_ready", 32'(all_ready), 32'h1);

    // Single-cycle loss of lock on channel 0
    lock_in[0] = 1'b0;
    step(1);
    lock_in[0] = 1'b1;
    step(4);
    check_eq("lol_domain_rst", 32'(domain_rst), 32'h3);
    check_eq("lol_all_ready",  32'(all_ready),  32'h0);
    step(30);
    check_eq("relock_all_ready", 32'(all_ready), 32'h1);

    // Glitch during debounce
    do_reset();
    lock_in = 2'b10;
    step(3);
    lock_in[0] = 1'b1;
    step(3);
    lock_in[0] = 1'b0;
    step(1);
    lock_in[0] = 1'b1;
    step(30);

    // Timeout into fault on channel 1, then clear
    do_reset();
    lock_in = 2'b01;
    step(60);
    check_eq("timeout_fault1",   32'(fault),         32'h2);
    check_eq("timeout_dom0_rel", 32'(domain_rst[0]), 32'h0);
    lock_in = 2'b11;
    clr     = 2'b11;
    step(1);
    clr = '0;
    check_eq("clear_fault_low", 32'(fault), 32'h0);
    step(30);
    check_eq("clear_all_ready", 32'(all_ready), 32'h1);

    // Async reset mid-debounce
    do_reset();
    lock_in = 2'b11;
    step(5);
    #2 reset = 1'b1;
    #1;
    check_eq("async_pll_reset",  32'(pll_reset),  32'h3);
    check_eq("async_domain_rst", 32'(domain_rst), 32'h3);
    check_eq("async_fault",      32'(fault),      32'h0);
    check_eq("async_all_ready",  32'(all_ready),  32'h0);
    check_eq("async_lol",        32'(lol_count),  32'h0);
    model_reset();
    step(2);
    reset = 1'b0;
    step(30);

    // Randomised lock behaviour and clear pulses
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) lock_in[i] = ~lock_in[i];
        clr[i] = ($urandom_range(0, 29) == 0);
      end
      step(1);
    end
    clr = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
